led_seq_ctl: RTL and testbench

LED_SEQ_CTL -- requirements
Module: led_seq_ctl

---
 rtl/led_seq_ctl_pkg.sv | 45 ++++
 rtl/led_seq_ctl_tick.sv | 36 +++
 rtl/led_seq_ctl.sv | 136 +++++++++++++
 tb/tb_led_seq_ctl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_ctl_pkg.sv
// Shared definitions for the LED sequencer: FSM state encoding, mode codes,
// the pattern each mode starts from, and the number of steps in one lap.
package led_seq_ctl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      MODE_CHASE_R = 2'd0,
      MODE_CHASE_L = 2'd1,
      MODE_PING    = 2'd2,
      MODE_FILL    = 2'd3
   } mode_t;

   localparam logic [15:0] PAT_TOP = 16'h8000;
   localparam logic [15:0] PAT_BOT = 16'h0001;
   localparam logic [15:0] PAT_CLR = 16'h0000;
   localparam logic [15:0] PAT_FULL = 16'hFFFF;

   // Steps needed to return to the starting pattern.
   localparam logic [4:0] LAP_LEN_CHASE = 5'd16;
   localparam logic [4:0] LAP_LEN_PING  = 5'd30;
   localparam logic [4:0] LAP_LEN_FILL  = 5'd17;

   function automatic logic [15:0] init_pat(input mode_t m);
      case (m)
         MODE_CHASE_L: init_pat = PAT_BOT;
         MODE_FILL:    init_pat = PAT_CLR;
         default:      init_pat = PAT_TOP;
      endcase
   endfunction

   function automatic logic [4:0] lap_len(input mode_t m);
      case (m)
         MODE_PING: lap_len = LAP_LEN_PING;
         MODE_FILL: lap_len = LAP_LEN_FILL;
         default:   lap_len = LAP_LEN_CHASE;
      endcase
   endfunction

endpackage

// File: rtl/led_seq_ctl_tick.sv
// Step prescaler: counts enabled cycles and pulses step on the last count of
// each TICK_DIV-cycle period. The count holds while en is low, so a paused
// sequence resumes exactly where it stopped.
//   clk  : clock
//   rst  : async active-high reset
//   en   : count this cycle
//   clr  : synchronous clear (dominates en)
//   step : high for the cycle whose edge advances the pattern
module led_tick_gen #(
   parameter int unsigned TICK_DIV = 3500
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic step
);

   localparam logic [23:0] LAST = 24'(TICK_DIV - 1);

   logic [23:0] r_cnt;
   logic        w_last;

   assign w_last = (r_cnt == LAST);
   assign step   = en && w_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (clr)
         r_cnt <= '0;
      else if (en)
         r_cnt <= w_last ? '0 : r_cnt + 24'd1;
   end

endmodule

// File: rtl/led_seq_ctl.sv
// LED pattern sequencer. Accepts a mode/lap-count command while idle, steps a
// 16-bit pattern every TICK_DIV cycles, and pulses done when the requested
// laps finish or the sequence is stopped.
//   clk, rst             : clock, async active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_mode, cmd_reps   : pattern mode, laps to run (0 = until stop)
//   pause, stop          : freeze stepping (level), abort sequence
//   led                  : current pattern
//   busy, done           : RUN/PAUSE indicator, one-cycle end pulse
module led_seq_ctl
   import led_seq_ctl_pkg::*;
#(
   parameter int unsigned TICK_DIV = 3500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_mode,
   input  logic [3:0]  cmd_reps,
   output logic        cmd_ready,
   input  logic        pause,
   input  logic        stop,
   output logic [15:0] led,
   output logic        busy,
   output logic        done
);

   state_t      r_state, w_state_nxt;
   mode_t       r_mode;
   logic [3:0]  r_reps;
   logic [3:0]  r_lap;
   logic [4:0]  r_step_cnt;   // steps taken within the current lap
   logic        r_dir;        // ping-pong direction: 0 right, 1 left
   logic [15:0] r_led;

   logic        w_accept, w_active, w_tick_en, w_step;
   logic        w_lap_end, w_finish;
   logic [3:0]  w_lap_nxt;
   logic [15:0] w_led_nxt;
   logic        w_dir_nxt;

   assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
   assign w_active  = (r_state == ST_RUN) || (r_state == ST_PAUSE);
   // Pause and stop both suppress the step on the cycle they appear.
   assign w_tick_en = (r_state == ST_RUN) && !pause && !stop;

   led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (w_tick_en),
      .clr  (r_state == ST_IDLE),
      .step (w_step)
   );

   assign w_lap_end = w_step && (r_step_cnt == lap_len(r_mode) - 5'd1);
   assign w_lap_nxt = r_lap + 4'd1;
   assign w_finish  = w_lap_end && (r_reps != 4'd0) && (w_lap_nxt == r_reps);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (cmd_valid) w_state_nxt = ST_RUN;
         ST_RUN: begin
            if (stop)          w_state_nxt = ST_DONE;
            else if (pause)    w_state_nxt = ST_PAUSE;
            else if (w_finish) w_state_nxt = ST_DONE;
         end
         ST_PAUSE: begin
            if (stop)        w_state_nxt = ST_DONE;
            else if (!pause) w_state_nxt = ST_RUN;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Next pattern for one step of the latched mode.
   always_comb begin
      w_led_nxt = r_led;
      w_dir_nxt = r_dir;
      case (r_mode)
         MODE_CHASE_R: w_led_nxt = {r_led[0], r_led[15:1]};
         MODE_CHASE_L: w_led_nxt = {r_led[14:0], r_led[15]};
         MODE_PING: begin
            w_led_nxt = r_dir ? (r_led << 1) : (r_led >> 1);
            // Turn around on arrival at an end so the end value is not repeated.
            if (w_led_nxt == PAT_BOT)
               w_dir_nxt = 1'b1;
            else if (w_led_nxt == PAT_TOP)
               w_dir_nxt = 1'b0;
         end
         default:      w_led_nxt = (r_led == PAT_FULL) ? PAT_CLR : {1'b1, r_led[15:1]};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode     <= MODE_CHASE_R;
         r_reps     <= '0;
         r_lap      <= '0;
         r_step_cnt <= '0;
         r_dir      <= 1'b0;
         r_led      <= PAT_CLR;
      end else if (w_accept) begin
         r_mode     <= mode_t'(cmd_mode);
         r_reps     <= cmd_reps;
         r_lap      <= '0;
         r_step_cnt <= '0;
         r_dir      <= 1'b0;
         r_led      <= init_pat(mode_t'(cmd_mode));
      end else if (w_active && stop) begin
         r_led      <= PAT_CLR;
      end else if (w_step) begin
         r_led      <= w_finish ? PAT_CLR : w_led_nxt;
         r_dir      <= w_dir_nxt;
         if (w_lap_end) begin
            r_lap      <= w_lap_nxt;
            r_step_cnt <= '0;
         end else begin
            r_step_cnt <= r_step_cnt + 5'd1;
         end
      end
   end

   assign led       = r_led;
   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = w_active;
   assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_led_seq_ctl.sv
module tb_led_seq_ctl;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [1:0]  cmd_mode;
   logic [3:0]  cmd_reps;
   logic        cmd_ready;
   logic        pause;
   logic        stop;
   logic [15:0] led;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_seq_ctl #(.TICK_DIV(TD)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_mode  (cmd_mode),
      .cmd_reps  (cmd_reps),
      .cmd_ready (cmd_ready),
      .pause     (pause),
      .stop      (stop),
      .led       (led),
      .busy      (busy),
      .done      (done)
   );

   // Pattern after k steps from the start of a sequence, derived directly
   // from the shape of each mode.
   function automatic logic [15:0] pat(input int mode, input int k);
      logic [15:0] one  = 16'h0001;
      logic [15:0] top  = 16'h8000;
      logic [15:0] full = 16'hFFFF;
      int p;
      case (mode)
         0: begin p = k % 16; return top >> p; end
         1: begin p = k % 16; return one << p; end
         2: begin p = k % 30; return (p <= 15) ? (top >> p) : (one << (p - 15)); end
         default: begin p = k % 17; return (p == 0) ? 16'h0000 : (full << (16 - p)); end
      endcase
   endfunction

   function automatic int lap_steps(input int mode);
      return (mode == 2) ? 30 : (mode == 3) ? 17 : 16;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input int mode, input int reps);
      cmd_mode  = mode[1:0];
      cmd_reps  = reps[3:0];
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_reps = 4'd0;
      pause = 1'b0; stop = 1'b0;
      tick(); tick();
      checks++;
      if ({led, cmd_ready, busy, done} !== {16'h0000, 3'b100})
         begin errors++; $display("FAIL reset_hold got led=%h rdy=%b busy=%b done=%b exp led=0000 rdy=1 busy=0 done=0", led, cmd_ready, busy, done); end
      rst = 1'b0;
      tick();
      checks++;
      if ({led, cmd_ready, busy, done} !== {16'h0000, 3'b100})
         begin errors++; $display("FAIL reset_release got led=%h rdy=%b busy=%b done=%b exp led=0000 rdy=1 busy=0 done=0", led, cmd_ready, busy, done); end
   endtask

   task automatic test_mode0_one_lap();
      logic [17:0] exp;
      accept(0, 1);
      checks++;
      if ({led, busy, cmd_ready} !== {16'h8000, 2'b10})
         begin errors++; $display("FAIL m0_start got led=%h busy=%b rdy=%b exp led=8000 busy=1 rdy=0", led, busy, cmd_ready); end
      for (int c = 1; c <= 64; c++) begin
         tick();
         exp = (c == 64) ? {16'h0000, 2'b01} : {pat(0, c / TD), 2'b10};
         checks++;
         if ({led, busy, done} !== exp)
            begin errors++; $display("FAIL m0_cycle%0d got %h/%b/%b exp %h", c, led, busy, done, exp); end
         if (c == 4) begin
            checks++;
            if (led !== 16'h4000) begin errors++; $display("FAIL m0_first_step got %h exp 4000", led); end
         end
      end
      tick();
      checks++;
      if ({done, cmd_ready} !== 2'b01)
         begin errors++; $display("FAIL m0_done_width got done=%b rdy=%b exp done=0 rdy=1", done, cmd_ready); end
   endtask

   task automatic test_full_laps(input int mode, input int reps, input int done_at);
      logic [17:0] exp;
      accept(mode, reps);
      for (int c = 1; c <= done_at; c++) begin
         tick();
         exp = (c == done_at) ? {16'h0000, 2'b01} : {pat(mode, c / TD), 2'b10};
         checks++;
         if ({led, busy, done} !== exp)
            begin errors++; $display("FAIL laps_m%0d_cycle%0d got %h/%b/%b exp %h", mode, c, led, busy, done, exp); end
      end
      tick();
      checks++;
      if ({done, cmd_ready} !== 2'b01)
         begin errors++; $display("FAIL laps_m%0d_idle got done=%b rdy=%b exp done=0 rdy=1", mode, done, cmd_ready); end
   endtask

   task automatic test_pause();
      accept(0, 0);
      tick(); tick(); tick();   // next edge would take the first step
      pause = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if ({led, busy} !== {16'h8000, 1'b1})
            begin errors++; $display("FAIL pause_hold%0d got led=%h busy=%b exp led=8000 busy=1", c, led, busy); end
      end
      pause = 1'b0;
      tick();
      checks++;
      if (led !== 16'h8000) begin errors++; $display("FAIL pause_resume got %h exp 8000", led); end
      tick();
      checks++;
      if (led !== 16'h4000) begin errors++; $display("FAIL pause_step_after_resume got %h exp 4000", led); end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if ({led, busy, done} !== {16'h0000, 2'b01})
         begin errors++; $display("FAIL pause_stop got %h/%b/%b exp 0000/0/1", led, busy, done); end
      tick();
   endtask

   // reps 0 runs past 16 laps (lap counter wrap) and ignores a mid-run command.
   task automatic test_ignore_and_stop();
      int n = 17 * 16 * TD + 3;
      accept(1, 0);
      for (int c = 1; c <= n; c++) begin
         if (c == 5) begin cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_reps = 4'd1; end
         else cmd_valid = 1'b0;
         tick();
         checks++;
         if ({led, busy, done, cmd_ready} !== {pat(1, c / TD), 3'b100})
            begin errors++; $display("FAIL ign_cycle%0d got %h/%b/%b/%b exp %h", c, led, busy, done, cmd_ready, pat(1, c / TD)); end
      end
      cmd_valid = 1'b0;
      pause = 1'b1;
      tick();
      checks++;
      if ({led, busy} !== {pat(1, n / TD), 1'b1})
         begin errors++; $display("FAIL ign_pause got %h/%b exp %h/1", led, busy, pat(1, n / TD)); end
      stop = 1'b1;
      tick();
      checks++;
      if ({led, busy, done} !== {16'h0000, 2'b01})
         begin errors++; $display("FAIL stop_in_pause got %h/%b/%b exp 0000/0/1", led, busy, done); end
      stop = 1'b0; pause = 1'b0;
      tick();
      checks++;
      if ({done, cmd_ready} !== 2'b01)
         begin errors++; $display("FAIL stop_idle got done=%b rdy=%b exp 0/1", done, cmd_ready); end
   endtask

   // Random commands with random pause activity; reps 0 ends with a random stop.
   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         int mode = $urandom_range(0, 3);
         int reps = $urandom_range(0, 2);
         int stop_at = (reps == 0) ? $urandom_range(10, 150) : -1;
         int eff = 0;
         bit paused = 1'b0;
         bit fin = 1'b0;
         logic [17:0] exp;
         accept(mode, reps);
         for (int c = 1; c < 2000 && !fin; c++) begin
            bit p = ($urandom_range(0, 9) == 0) ? !pause : pause;
            bit s = (c == stop_at);
            pause = p;
            stop  = s;
            if (!s) begin
               if (!paused) begin
                  if (p) paused = 1'b1; else eff++;
               end else if (!p) paused = 1'b0;
            end
            tick();
            if (s || (reps != 0 && eff / TD == reps * lap_steps(mode))) begin
               fin = 1'b1;
               exp = {16'h0000, 2'b01};
            end else begin
               exp = {pat(mode, eff / TD), 2'b10};
            end
            checks++;
            if ({led, busy, done} !== exp)
               begin errors++; $display("FAIL rand%0d_m%0d_r%0d_cycle%0d got %h/%b/%b exp %h", n, mode, reps, c, led, busy, done, exp); end
         end
         pause = 1'b0; stop = 1'b0;
         checks++;
         if (!fin) begin errors++; $display("FAIL rand%0d_timeout got no end exp end within 2000 cycles", n); end
         tick();
         checks++;
         if ({done, cmd_ready} !== 2'b01)
            begin errors++; $display("FAIL rand%0d_idle got done=%b rdy=%b exp 0/1", n, done, cmd_ready); end
      end
   endtask

   task automatic test_reset_mid_run();
      accept(2, 0);
      repeat (20) tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({led, cmd_ready, busy, done} !== {16'h0000, 3'b100})
         begin errors++; $display("FAIL async_reset got led=%h rdy=%b busy=%b done=%b exp 0000/1/0/0", led, cmd_ready, busy, done); end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({led, cmd_ready, busy, done} !== {16'h0000, 3'b100})
            begin errors++; $display("FAIL reset_no_done%0d got led=%h rdy=%b busy=%b done=%b exp 0000/1/0/0", c, led, cmd_ready, busy, done); end
      end
   endtask

   initial begin
      test_reset();
      test_mode0_one_lap();
      test_full_laps(2, 2, 240);
      test_full_laps(3, 1, 68);
      test_full_laps(1, 1, 64);
      test_pause();
      test_ignore_and_stop();
      test_random();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
